// File: rtl/trap_ctrl_if.sv
// Interface between the commit stage, the CSR unit and the trap sequencer.
// The master side (ROB / CSR unit) drives the event and control inputs;
// the slave side (trap_ctrl) drives the trap record, redirect and stall.
interface trap_ctrl_if #(
   parameter int SQN_W = 7
);
   logic             head_valid;
   logic [31:0]      head_pc;
   logic [SQN_W-1:0] head_sqn;
   logic             exc_valid;
   logic [3:0]       exc_cause;
   logic             mret_valid;
   logic [31:0]      mepc;
   logic [2:0]       irq_pending;
   logic             irq_enable;
   logic [30:0]      trap_control;
   logic [37:0]      trap_info;
   logic             flush_valid;
   logic [31:0]      flush_pc;
   logic [SQN_W-1:0] flush_sqn;
   logic             busy;

   modport master (
      output head_valid, head_pc, head_sqn, exc_valid, exc_cause,
             mret_valid, mepc, irq_pending, irq_enable, trap_control,
      input  trap_info, flush_valid, flush_pc, flush_sqn, busy
   );

   modport slave (
      input  head_valid, head_pc, head_sqn, exc_valid, exc_cause,
             mret_valid, mepc, irq_pending, irq_enable, trap_control,
      output trap_info, flush_valid, flush_pc, flush_sqn, busy
   );
endinterface

// File: rtl/trap_ctrl.sv
// Commit-side trap sequencer. Picks one event from the ROB head (exception,
// MRET or enabled interrupt), emits one trap record and one redirect pulse,
// then stalls commit for a fixed drain period before looking again.
module trap_ctrl #(
   parameter int SQN_W        = 7,
   parameter int DRAIN_CYCLES = 4
) (
   input logic        clk,
   input logic        rst_n,
   trap_ctrl_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FIRE  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]       state;
   logic [3:0]       drain_cnt;

   logic [3:0]       lat_cause;
   logic             lat_int;
   logic             lat_mret;
   logic [31:0]      lat_pc;
   logic [SQN_W-1:0] lat_sqn;
   logic [31:0]      lat_target;

   logic             irq_any;
   logic             accept;
   logic [3:0]       irq_cause;
   logic [31:0]      tvec_base;
   logic [3:0]       acc_cause;
   logic             acc_int;
   logic             acc_mret;
   logic [31:0]      acc_target;
   logic             fire;

   // Event arbitration and redirect target for whatever the head offers now
   always_comb begin
      irq_any    = bus.irq_enable && (|bus.irq_pending);
      accept     = (state == IDLE) && bus.head_valid &&
                   (bus.exc_valid || bus.mret_valid || irq_any);
      irq_cause  = bus.irq_pending[2] ? 4'd11 :
                   bus.irq_pending[0] ? 4'd3  : 4'd7;
      tvec_base  = {bus.trap_control[30:1], 2'b00};
      acc_cause  = 4'd0;
      acc_int    = 1'b0;
      acc_mret   = 1'b0;
      acc_target = tvec_base;
      if (bus.exc_valid) begin
         acc_cause = bus.exc_cause;
      end else if (bus.mret_valid) begin
         acc_mret   = 1'b1;
         acc_target = {bus.mepc[31:1], 1'b0};
      end else begin
         acc_cause = irq_cause;
         acc_int   = 1'b1;
         if (bus.trap_control[0])
            acc_target = tvec_base + {26'b0, irq_cause, 2'b00};
      end
   end

   // Sequencer: one FIRE cycle, then a fixed number of DRAIN cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         drain_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept)
                  state <= FIRE;
            end
            FIRE: begin
               state     <= DRAIN;
               drain_cnt <= 4'(DRAIN_CYCLES);
            end
            DRAIN: begin
               drain_cnt <= drain_cnt - 4'd1;
               if (drain_cnt == 4'd1)
                  state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               drain_cnt <= 4'd0;
            end
         endcase
      end
   end

   // Capture the accepted event so the outputs stay stable after FIRE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_cause  <= 4'd0;
         lat_int    <= 1'b0;
         lat_mret   <= 1'b0;
         lat_pc     <= 32'd0;
         lat_sqn    <= '0;
         lat_target <= 32'd0;
      end else if (accept) begin
         lat_cause  <= acc_cause;
         lat_int    <= acc_int;
         lat_mret   <= acc_mret;
         lat_pc     <= bus.head_pc;
         lat_sqn    <= bus.head_sqn;
         lat_target <= acc_target;
      end
   end

   assign fire            = (state == FIRE);
   assign bus.busy        = (state != IDLE);
   assign bus.flush_valid = fire;
   assign bus.flush_pc    = lat_target;
   assign bus.flush_sqn   = lat_sqn;
   assign bus.trap_info   = {fire && !lat_mret, lat_cause, lat_int, lat_pc};

endmodule
